// File: rtl/rob_commit_buffer_if.sv
// ============================================================================
// rob_commit_buffer_if : dispatch / CDB / read-port / commit bundle for the ROB
// Rev 1.0
// ============================================================================
`default_nettype none

interface rob_commit_buffer_if #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
);
  logic              alloc_valid;
  logic [4:0]        alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  rd_tag_a;
  logic [TAG_W-1:0]  rd_tag_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_ready_a;
  logic              rd_ready_b;
  logic              commit_load;
  logic [4:0]        commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic              empty;

  modport master (
    output alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag_a, rd_tag_b,
    input  alloc_ready, alloc_tag, rd_data_a, rd_data_b, rd_ready_a, rd_ready_b,
           commit_load, commit_dest, commit_data, commit_tag, empty
  );

  modport slave (
    input  alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag_a, rd_tag_b,
    output alloc_ready, alloc_tag, rd_data_a, rd_data_b, rd_ready_a, rd_ready_b,
           commit_load, commit_dest, commit_data, commit_tag, empty
  );
endinterface

`default_nettype wire

// File: rtl/rob_commit_buffer.sv
// ============================================================================
// rob_commit_buffer : 8-entry in-order-retire ROB feeding a tagged regfile.
// Optional macro ROB_CDB_FWD_EN: read ports bypass the same-cycle CDB.
// Rev 1.0
// ============================================================================
`default_nettype none

module rob_commit_buffer #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  rob_commit_buffer_if.slave bus
);

  localparam int               DEPTH      = 1 << TAG_W;
  localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W + 1)'(DEPTH);

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  done;
  logic [4:0]        dest [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count;

  logic alloc_fire;
  logic cdb_hit;
  logic head_ready;
  logic hazard;
  logic commit;

  assign bus.alloc_ready = (count != FULL_COUNT);
  assign bus.alloc_tag   = tail;
  assign bus.empty       = (count == '0);

  assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
  assign cdb_hit    = bus.cdb_valid && valid[bus.cdb_tag] && !done[bus.cdb_tag];
  assign head_ready = valid[head] && done[head];

  // The regfile gives load priority over allocate, so retiring into the register
  // that is being re-tagged this cycle would overwrite the fresh tag.
  assign hazard = alloc_fire && (bus.alloc_dest == dest[head]) && (dest[head] != 5'd0);
  assign commit = head_ready && !hazard;

  assign bus.commit_load = commit && (dest[head] != 5'd0);
  assign bus.commit_dest = dest[head];
  assign bus.commit_data = data[head];
  assign bus.commit_tag  = head;

  always_comb begin
    bus.rd_ready_a = valid[bus.rd_tag_a] && done[bus.rd_tag_a];
    bus.rd_data_a  = data[bus.rd_tag_a];
    bus.rd_ready_b = valid[bus.rd_tag_b] && done[bus.rd_tag_b];
    bus.rd_data_b  = data[bus.rd_tag_b];
`ifdef ROB_CDB_FWD_EN
    if (bus.cdb_valid && (bus.cdb_tag == bus.rd_tag_a) && valid[bus.rd_tag_a]) begin
      bus.rd_ready_a = 1'b1;
      bus.rd_data_a  = bus.cdb_data;
    end
    if (bus.cdb_valid && (bus.cdb_tag == bus.rd_tag_b) && valid[bus.rd_tag_b]) begin
      bus.rd_ready_b = 1'b1;
      bus.rd_data_b  = bus.cdb_data;
    end
`endif
  end

  // Slots touched by CDB, commit and alloc in one cycle never coincide: the CDB
  // needs a valid not-done entry, commit a done head, alloc a free tail.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      if (cdb_hit) begin
        data[bus.cdb_tag] <= bus.cdb_data;
        done[bus.cdb_tag] <= 1'b1;
      end
      if (commit) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + 1'b1;
      end
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        dest[tail]  <= bus.alloc_dest;
        tail        <= tail + 1'b1;
      end
      case ({alloc_fire, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_buffer.sv
// ============================================================================
// tb_rob_commit_buffer : vector table + commit scoreboard for rob_commit_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rob_commit_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rob_commit_buffer_if #(.TAG_W(3), .DATA_W(32)) bus ();

  rob_commit_buffer #(.TAG_W(3), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] tag;
    logic [4:0] dest;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] sb_data [8];

  typedef struct packed {
    logic        av;
    logic [4:0]  ad;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    logic [2:0]  ra;
    logic        e_rdy;
    logic [2:0]  e_tag;
    logic        e_empty;
    logic        e_cl;
    logic [4:0]  e_cdest;
    logic [31:0] e_cdata;
    logic        e_rra;
    logic [31:0] e_rda;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ad, input logic cv,
                       input logic [2:0] ct, input logic [31:0] cd,
                       input logic [2:0] ra, input logic [2:0] rb);
    bus.alloc_valid = av;
    bus.alloc_dest  = ad;
    bus.cdb_valid   = cv;
    bus.cdb_tag     = ct;
    bus.cdb_data    = cd;
    bus.rd_tag_a    = ra;
    bus.rd_tag_b    = rb;
    if (cv) sb_data[ct] = cd;
  endtask

  task automatic sb_push(input logic [2:0] tag, input logic [4:0] dest);
    if (dest != 5'd0) sb_q.push_back('{tag: tag, dest: dest});
  endtask

  // Reset asserted alongside an alloc request: the request must be discarded.
  task automatic do_reset();
    rst = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 3'd0, 32'h5a5a, 3'd3, 3'd3);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd3, 3'd3);
    sb_q.delete();
  endtask

  // Every regfile write must match the oldest outstanding non-x0 allocation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.commit_load === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_commit", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_commit_tag",  32'(bus.commit_tag),  32'(e.tag));
        chk("sb_commit_dest", 32'(bus.commit_dest), 32'(e.dest));
        chk("sb_commit_data", bus.commit_data,      sb_data[e.tag]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) sb_data[i] = 32'd0;

    // Reset, fill to full, drop a 9th alloc, out-of-order CDB, full-with-commit.
    vt[0] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0};
    for (int i = 1; i <= 8; i++)
      vt[i] = '{1'b1, 5'(i), 1'b0, 3'd0, 32'd0, 3'd0, 1'b1, 3'(i - 1), 1'(i == 1), 1'b0,
                (i == 1) ? 5'd0 : 5'd1, 32'd0, 1'b0, 32'd0};
    vt[9]  = '{1'b1, 5'd9,  1'b0, 3'd0, 32'd0,      3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 32'd0,      1'b0, 32'd0};
    vt[10] = '{1'b0, 5'd0,  1'b0, 3'd0, 32'd0,      3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 32'd0,      1'b0, 32'd0};
    vt[11] = '{1'b0, 5'd0,  1'b1, 3'd1, 32'hbeef,   3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 32'd0,      1'b0, 32'd0};
    vt[12] = '{1'b0, 5'd0,  1'b1, 3'd0, 32'h1234,   3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 32'd0,      1'b1, 32'hbeef};
    vt[13] = '{1'b1, 5'd20, 1'b0, 3'd0, 32'd0,      3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd1, 32'h1234,   1'b1, 32'h1234};
    vt[14] = '{1'b1, 5'd20, 1'b0, 3'd0, 32'd0,      3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 5'd2, 32'hbeef,   1'b0, 32'h1234};

    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    next_cycle();
    next_cycle();
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].av, vt[i].ad, vt[i].cv, vt[i].ct, vt[i].cd, vt[i].ra, 3'd0);
      if (vt[i].av && vt[i].e_rdy) sb_push(vt[i].e_tag, vt[i].ad);
      @(negedge clk);
      chk($sformatf("v%0d.alloc_ready", i), 32'(bus.alloc_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d.alloc_tag", i),   32'(bus.alloc_tag),   32'(vt[i].e_tag));
      chk($sformatf("v%0d.empty", i),       32'(bus.empty),       32'(vt[i].e_empty));
      chk($sformatf("v%0d.commit_load", i), 32'(bus.commit_load), 32'(vt[i].e_cl));
      chk($sformatf("v%0d.commit_dest", i), 32'(bus.commit_dest), 32'(vt[i].e_cdest));
      chk($sformatf("v%0d.commit_data", i), bus.commit_data,      vt[i].e_cdata);
      chk($sformatf("v%0d.rd_ready_a", i),  32'(bus.rd_ready_a),  32'(vt[i].e_rra));
      chk($sformatf("v%0d.rd_data_a", i),   bus.rd_data_a,        vt[i].e_rda);
      next_cycle();
    end

    // Mid-operation reset with live entries.
    do_reset();
    @(negedge clk);
    chk("rst.empty",       32'(bus.empty),       32'd1);
    chk("rst.alloc_tag",   32'(bus.alloc_tag),   32'd0);
    chk("rst.alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst.commit_dest", 32'(bus.commit_dest), 32'd0);
    chk("rst.rd_data_a",   bus.rd_data_a,        32'd0);

    // Hazard stall: head dest 5 done while dispatch re-tags r5.
    next_cycle();
    drive(1'b1, 5'd5, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    sb_push(3'd0, 5'd5);
    next_cycle();
    drive(1'b0, 5'd0, 1'b1, 3'd0, 32'h55, 3'd0, 3'd0);
    next_cycle();
    drive(1'b1, 5'd5, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    sb_push(3'd1, 5'd5);
    @(negedge clk);
    chk("haz.commit_load", 32'(bus.commit_load), 32'd0);
    chk("haz.alloc_tag",   32'(bus.alloc_tag),   32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    @(negedge clk);
    chk("haz_next.commit_load", 32'(bus.commit_load), 32'd1);
    chk("haz_next.commit_data", bus.commit_data,      32'h55);
    next_cycle();

    // x0 destination retires silently.
    drive(1'b1, 5'd0, 1'b1, 3'd1, 32'h77, 3'd0, 3'd0);
    @(negedge clk);
    chk("x0.alloc_tag",   32'(bus.alloc_tag),   32'd2);
    chk("x0.commit_load", 32'(bus.commit_load), 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 1'b1, 3'd2, 32'h99, 3'd0, 3'd0);
    @(negedge clk);
    chk("x0.prev_commit_load", 32'(bus.commit_load), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    @(negedge clk);
    chk("x0.retire_load", 32'(bus.commit_load), 32'd0);
    chk("x0.commit_tag",  32'(bus.commit_tag),  32'd2);
    chk("x0.commit_data", bus.commit_data,      32'h99);
    chk("x0.empty_before", 32'(bus.empty),      32'd0);
    next_cycle();
    @(negedge clk);
    chk("x0.empty_after", 32'(bus.empty),     32'd1);
    chk("x0.alloc_tag3",  32'(bus.alloc_tag), 32'd3);

    // Read ports.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
      sb_push(3'(i), 5'(i + 1));
      next_cycle();
    end
    drive(1'b0, 5'd0, 1'b1, 3'd3, 32'hcafe, 3'd3, 3'd3);
    @(negedge clk);
`ifdef ROB_CDB_FWD_EN
    chk("rd.fwd_ready_a", 32'(bus.rd_ready_a), 32'd1);
    chk("rd.fwd_data_a",  bus.rd_data_a,       32'hcafe);
`else
    chk("rd.same_cycle_ready_a", 32'(bus.rd_ready_a), 32'd0);
    chk("rd.same_cycle_data_a",  bus.rd_data_a,       32'd0);
`endif
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd3, 3'd3);
    @(negedge clk);
    chk("rd.ready_a", 32'(bus.rd_ready_a), 32'd1);
    chk("rd.data_a",  bus.rd_data_a,       32'hcafe);
    chk("rd.ready_b", 32'(bus.rd_ready_b), 32'd1);
    chk("rd.data_b",  bus.rd_data_b,       32'hcafe);
    next_cycle();
    drive(1'b0, 5'd0, 1'b1, 3'd3, 32'hdead, 3'd3, 3'd5);
    next_cycle();
    drive(1'b0, 5'd0, 1'b1, 3'd5, 32'h1111, 3'd3, 3'd5);
    @(negedge clk);
    chk("rd.done_cdb_ignored", bus.rd_data_a, 32'hcafe);
    next_cycle();
    drive(1'b1, 5'd9, 1'b1, 3'd4, 32'h4444, 3'd3, 3'd5);
    sb_push(3'd4, 5'd9);
    @(negedge clk);
    chk("rd.invalid_cdb_ready_b", 32'(bus.rd_ready_b), 32'd0);
    chk("rd.invalid_cdb_data_b",  bus.rd_data_b,       32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd3, 3'd4);
    @(negedge clk);
    chk("rd.alloc_cdb_ready_b", 32'(bus.rd_ready_b), 32'd0);
    chk("rd.alloc_cdb_data_b",  bus.rd_data_b,       32'd0);
    chk("rd.alloc_tag5",        32'(bus.alloc_tag),  32'd5);
    chk("rd.head_blocked",      32'(bus.commit_load), 32'd0);
    next_cycle();

    do_reset();
    @(negedge clk);
    chk("rst2.empty",      32'(bus.empty),      32'd1);
    chk("rst2.alloc_tag",  32'(bus.alloc_tag),  32'd0);
    chk("rst2.rd_ready_a", 32'(bus.rd_ready_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
